// File: rtl/inst_mem_loader.sv
// Serial program loader: assembles little-endian words from a byte stream,
// writes them into instruction memory and holds the CPU in reset until the image is complete.
module inst_mem_loader #(
  parameter int ROM_WIDTH     = 32,
  parameter int ROM_ADDR_BITS = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  input  logic                     load_req,
  output logic                     we,
  output logic [ROM_ADDR_BITS-1:0] waddr,
  output logic [ROM_WIDTH-1:0]     wdata,
  output logic                     cpu_rst,
  output logic                     done,
  output logic                     err,
  output logic [ROM_ADDR_BITS-2:0] words_loaded
);

  localparam int MAX_WORDS = (2 ** ROM_ADDR_BITS) / 4;
  localparam int WI_W      = ROM_ADDR_BITS - 2;
  localparam int WL_W      = ROM_ADDR_BITS - 1;

  localparam logic [15:0]     MAX_N  = 16'(MAX_WORDS);
  localparam logic [WI_W-1:0] WI_ONE = WI_W'(1);
  localparam logic [WL_W-1:0] WL_ONE = WL_W'(1);

  typedef enum logic [2:0] {
    S_CNT_LO = 3'd0,
    S_CNT_HI = 3'd1,
    S_DATA   = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t          state_r;
  logic [15:0]     cnt_r;
  logic [1:0]      byte_idx_r;
  logic [WI_W-1:0] word_idx_r;
  logic [23:0]     shift_r;

  logic [15:0]     cnt_next_s;
  logic            last_word_s;

  assign cnt_next_s  = {byte_data, cnt_r[7:0]};
  assign last_word_s = (16'(word_idx_r) == (cnt_r - 16'd1));

  // Loader FSM; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_CNT_LO;
      cnt_r        <= 16'd0;
      byte_idx_r   <= 2'd0;
      word_idx_r   <= '0;
      shift_r      <= 24'd0;
      we           <= 1'b0;
      waddr        <= '0;
      wdata        <= '0;
      cpu_rst      <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      we <= 1'b0;
      case (state_r)
        S_CNT_LO: begin
          if (byte_valid) begin
            cnt_r[7:0] <= byte_data;
            state_r    <= S_CNT_HI;
          end else begin
            state_r    <= S_CNT_LO;
          end
        end

        S_CNT_HI: begin
          if (byte_valid) begin
            cnt_r <= cnt_next_s;
            if (cnt_next_s == 16'd0) begin
              state_r <= S_DONE;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else if (cnt_next_s > MAX_N) begin
              state_r <= S_ERR;
              err     <= 1'b1;
            end else begin
              state_r    <= S_DATA;
              byte_idx_r <= 2'd0;
              word_idx_r <= '0;
            end
          end else begin
            state_r <= S_CNT_HI;
          end
        end

        S_DATA: begin
          if (byte_valid) begin
            shift_r    <= {byte_data, shift_r[23:8]};
            byte_idx_r <= byte_idx_r + 2'd1;
            if (byte_idx_r == 2'd3) begin
              // Fourth byte goes straight into the write word, no extra cycle.
              state_r      <= S_WRITE;
              we           <= 1'b1;
              waddr        <= {word_idx_r, 2'b00};
              wdata        <= {byte_data, shift_r};
              words_loaded <= words_loaded + WL_ONE;
            end else begin
              state_r <= S_DATA;
            end
          end else begin
            state_r <= S_DATA;
          end
        end

        S_WRITE: begin
          if (last_word_s) begin
            state_r <= S_DONE;
            done    <= 1'b1;
            cpu_rst <= 1'b0;
          end else begin
            state_r    <= S_DATA;
            word_idx_r <= word_idx_r + WI_ONE;
            // A byte landing during the write strobe is lane 0 of the next word.
            if (byte_valid) begin
              shift_r    <= {byte_data, shift_r[23:8]};
              byte_idx_r <= 2'd1;
            end else begin
              byte_idx_r <= 2'd0;
            end
          end
        end

        S_DONE: begin
          if (load_req) begin
            state_r      <= S_CNT_LO;
            cpu_rst      <= 1'b1;
            done         <= 1'b0;
            words_loaded <= '0;
            cnt_r        <= 16'd0;
            byte_idx_r   <= 2'd0;
            word_idx_r   <= '0;
          end else begin
            state_r <= S_DONE;
          end
        end

        S_ERR: begin
          if (load_req) begin
            state_r      <= S_CNT_LO;
            err          <= 1'b0;
            words_loaded <= '0;
            cnt_r        <= 16'd0;
            byte_idx_r   <= 2'd0;
            word_idx_r   <= '0;
          end else begin
            state_r <= S_ERR;
          end
        end

        default: begin
          state_r <= S_CNT_LO;
          cpu_rst <= 1'b1;
          done    <= 1'b0;
          err     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed testbench for inst_mem_loader: per-scenario tasks with inline checks
// against hand-computed expectations.
module tb_inst_mem_loader;

  logic        clk;
  logic        rst;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        load_req;
  logic        we;
  logic [9:0]  waddr;
  logic [31:0] wdata;
  logic        cpu_rst;
  logic        done;
  logic        err;
  logic [8:0]  words_loaded;

  int checks = 0;
  int errors = 0;

  // Write log filled by the monitor below.
  logic [9:0]  log_addr [0:63];
  logic [31:0] log_data [0:63];
  int          we_total  = 0;
  int          we_double = 0;
  logic        we_prev   = 1'b0;

  inst_mem_loader #(.ROM_WIDTH(32), .ROM_ADDR_BITS(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .load_req     (load_req),
    .we           (we),
    .waddr        (waddr),
    .wdata        (wdata),
    .cpu_rst      (cpu_rst),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write strobe mid-cycle and flag back-to-back strobes.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (we_total < 64) begin
        log_addr[we_total] = waddr;
        log_data[we_total] = wdata;
      end
      we_total = we_total + 1;
      if (we_prev === 1'b1) we_double = we_double + 1;
    end
    we_prev = we;
  end

  // Present inputs for one clock; returns 1 time unit after the consuming edge.
  task automatic cycle(input logic bv, input logic [7:0] bd, input logic lr);
    byte_valid = bv;
    byte_data  = bd;
    load_req   = lr;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    load_req   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle(1'b1, 8'h55, 1'b0);
    rst = 1'b0;
    checks++;
    if ({we, waddr, wdata} !== {1'b0, 10'h000, 32'h0}) begin
      errors++;
      $display("FAIL reset_wr: we/waddr/wdata=%b/%h/%h required 0/000/00000000", we, waddr, wdata);
    end
    checks++;
    if ({cpu_rst, done, err, words_loaded} !== {1'b1, 1'b0, 1'b0, 9'd0}) begin
      errors++;
      $display("FAIL reset_status: cpu_rst/done/err/wl=%b/%b/%b/%0d required 1/0/0/0",
               cpu_rst, done, err, words_loaded);
    end
  endtask

  task automatic test_basic();
    logic [7:0] s [0:9];
    int base;
    s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    do_reset();
    base = we_total;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, s[i], 1'b0);
      if (i == 5 || i == 9) begin
        checks++;
        if (we !== 1'b1 || waddr !== ((i == 5) ? 10'h000 : 10'h004)) begin
          errors++;
          $display("FAIL basic_latency byte %0d: we=%b waddr=%h required 1 and %h",
                   i, we, waddr, (i == 5) ? 10'h000 : 10'h004);
        end
      end
      if (i == 9) begin
        checks++;
        if (cpu_rst !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL basic_in_write: cpu_rst=%b done=%b required 1 0", cpu_rst, done);
        end
      end
      cycle(1'b0, 8'h00, 1'b0);
    end
    checks++;
    if ({done, cpu_rst, words_loaded} !== {1'b1, 1'b0, 9'd2}) begin
      errors++;
      $display("FAIL basic_done: done/cpu_rst/wl=%b/%b/%0d required 1/0/2", done, cpu_rst, words_loaded);
    end
    checks++;
    if (we_total - base !== 2) begin
      errors++;
      $display("FAIL basic_count: writes=%0d required 2", we_total - base);
    end else begin
      checks++;
      if (log_addr[base] !== 10'h000 || log_data[base] !== 32'h00000013) begin
        errors++;
        $display("FAIL basic_w0: %h/%h required 000/00000013", log_addr[base], log_data[base]);
      end
      checks++;
      if (log_addr[base+1] !== 10'h004 || log_data[base+1] !== 32'h00100093) begin
        errors++;
        $display("FAIL basic_w1: %h/%h required 004/00100093", log_addr[base+1], log_data[base+1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    logic [31:0] exp_d [0:2];
    exp_d = '{32'h14131211, 32'h18171615, 32'h1C1B1A19};
    do_reset();
    base = we_total;
    cycle(1'b1, 8'h03, 1'b0);
    cycle(1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b1, 8'(8'h11 + i), 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (we_total - base !== 3) begin
      errors++;
      $display("FAIL b2b_count: writes=%0d required 3", we_total - base);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (log_addr[base+k] !== 10'(4 * k) || log_data[base+k] !== exp_d[k]) begin
          errors++;
          $display("FAIL b2b_w%0d: %h/%h required %h/%h", k, log_addr[base+k], log_data[base+k],
                   10'(4 * k), exp_d[k]);
        end
      end
    end
    checks++;
    if ({done, cpu_rst, words_loaded} !== {1'b1, 1'b0, 9'd3}) begin
      errors++;
      $display("FAIL b2b_done: done/cpu_rst/wl=%b/%b/%0d required 1/0/3", done, cpu_rst, words_loaded);
    end
  endtask

  task automatic test_err();
    int base;
    do_reset();
    base = we_total;
    cycle(1'b1, 8'h01, 1'b0);
    cycle(1'b1, 8'h01, 1'b0);
    checks++;
    if ({err, cpu_rst, done} !== {1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL err_set: err/cpu_rst/done=%b/%b/%b required 1/1/0", err, cpu_rst, done);
    end
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'h00, 1'b0);
    checks++;
    if (err !== 1'b1 || we_total != base) begin
      errors++;
      $display("FAIL err_hold: err=%b writes=%0d required 1 and 0", err, we_total - base);
    end
    cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (err !== 1'b0 || cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL err_clear: err=%b cpu_rst=%b required 0 1", err, cpu_rst);
    end
    // Back in CNT_LO: an empty header must now complete.
    cycle(1'b1, 8'h00, 1'b0);
    cycle(1'b1, 8'h00, 1'b0);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL err_restart: done=%b required 1", done);
    end
  endtask

  task automatic test_zero();
    int base;
    do_reset();
    base = we_total;
    cycle(1'b1, 8'h00, 1'b0);
    checks++;
    if (done !== 1'b0 || cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL zero_mid: done=%b cpu_rst=%b required 0 1", done, cpu_rst);
    end
    cycle(1'b1, 8'h00, 1'b0);
    checks++;
    if ({done, cpu_rst, err, words_loaded} !== {1'b1, 1'b0, 1'b0, 9'd0}) begin
      errors++;
      $display("FAIL zero_done: done/cpu_rst/err/wl=%b/%b/%b/%0d required 1/0/0/0",
               done, cpu_rst, err, words_loaded);
    end
    cycle(1'b1, 8'h12, 1'b0);
    checks++;
    if (we_total != base || done !== 1'b1) begin
      errors++;
      $display("FAIL zero_nowrite: writes=%0d done=%b required 0 1", we_total - base, done);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] s [0:7];
    int base;
    s = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, s[i], 1'b0);
    checks++;
    if (words_loaded !== 9'd1) begin
      errors++;
      $display("FAIL mid_partial: wl=%0d required 1", words_loaded);
    end
    rst = 1'b1;
    cycle(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    checks++;
    if ({cpu_rst, done, words_loaded} !== {1'b1, 1'b0, 9'd0}) begin
      errors++;
      $display("FAIL mid_reset: cpu_rst/done/wl=%b/%b/%0d required 1/0/0", cpu_rst, done, words_loaded);
    end
    base = we_total;
    cycle(1'b1, 8'h01, 1'b0);
    cycle(1'b1, 8'h00, 1'b0);
    cycle(1'b1, 8'hAA, 1'b0);
    cycle(1'b1, 8'hBB, 1'b0);
    cycle(1'b1, 8'hCC, 1'b0);
    cycle(1'b1, 8'hDD, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (we_total - base !== 1 || log_addr[base] !== 10'h000 || log_data[base] !== 32'hDDCCBBAA) begin
      errors++;
      $display("FAIL mid_fresh: writes=%0d %h/%h required 1 000/ddccbbaa",
               we_total - base, log_addr[base], log_data[base]);
    end
    checks++;
    if ({done, cpu_rst, words_loaded} !== {1'b1, 1'b0, 9'd1}) begin
      errors++;
      $display("FAIL mid_done: done/cpu_rst/wl=%b/%b/%0d required 1/0/1", done, cpu_rst, words_loaded);
    end
  endtask

  task automatic test_reload();
    int base;
    // Entered from DONE with one word loaded.
    cycle(1'b1, 8'hAA, 1'b1);
    checks++;
    if ({cpu_rst, done, words_loaded} !== {1'b1, 1'b0, 9'd0}) begin
      errors++;
      $display("FAIL reload_restart: cpu_rst/done/wl=%b/%b/%0d required 1/0/0", cpu_rst, done, words_loaded);
    end
    base = we_total;
    cycle(1'b1, 8'h01, 1'b0);
    cycle(1'b1, 8'h00, 1'b0);
    checks++;
    if (err !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reload_count: err=%b done=%b required 0 0", err, done);
    end
    for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (we_total - base !== 1 || log_addr[base] !== 10'h000 || log_data[base] !== 32'h04030201) begin
      errors++;
      $display("FAIL reload_word: writes=%0d %h/%h required 1 000/04030201",
               we_total - base, log_addr[base], log_data[base]);
    end
    checks++;
    if ({done, cpu_rst} !== {1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reload_done: done/cpu_rst=%b/%b required 1/0", done, cpu_rst);
    end
  endtask

  initial begin
    rst        = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    load_req   = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_err();
    test_zero();
    test_reset_mid();
    test_reload();
    checks++;
    if (we_double != 0) begin
      errors++;
      $display("FAIL we_single: back-to-back strobes=%0d required 0", we_double);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
